// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the ID-stage main decoder and the EX-stage ALU control.
// Holds the opcode encodings, the ALU operation selector and the packed control bundle.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_ADD};

endpackage

// File: rtl/main_decoder.sv
// Combinational main control decoder: opcode to control bundle plus illegal-opcode flag.
module main_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT};
            OP_LW:    ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OP_ADD};
            OP_SW:    ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OP_ADD};
            OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OP_SUB};
            OP_ADDI:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_OP_ADD};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_id_ex.sv
// Main control decode plus ID/EX control pipeline register with stall/flush handling
// and a saturating illegal-opcode counter.
module control_id_ex
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_if_id,
    input  logic [5:0]       opcode_if_id,
    input  logic [5:0]       func_if_id,
    input  logic             stall,
    input  logic             flush,
    output logic             valid_id_ex,
    output logic             reg_dst_id_ex,
    output logic             alu_src_id_ex,
    output logic             mem_to_reg_id_ex,
    output logic             reg_write_id_ex,
    output logic             mem_read_id_ex,
    output logic             mem_write_id_ex,
    output logic             branch_id_ex,
    output logic [1:0]       alu_op_id_ex,
    output logic [5:0]       func_id_ex,
    output logic             illegal_id_ex,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic             load;

    ctrl_t            ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [5:0]       func_d, func_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    main_decoder u_main_decoder (
        .opcode  (opcode_if_id),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign load = !flush && !stall;

    // Flush outranks stall; a plain load of an empty slot is also a bubble.
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        func_d    = func_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush || (load && !valid_if_id)) begin
            ctrl_d    = CTRL_NOP;
            valid_d   = 1'b0;
            func_d    = 6'd0;
            illegal_d = 1'b0;
        end else if (load) begin
            ctrl_d    = dec_ctrl;
            valid_d   = 1'b1;
            func_d    = func_if_id;
            illegal_d = dec_illegal;
        end
        if (load && valid_if_id && dec_illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= CTRL_NOP;
            valid_q   <= 1'b0;
            func_q    <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            func_q    <= func_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_id_ex      = valid_q;
    assign reg_dst_id_ex    = ctrl_q.reg_dst;
    assign alu_src_id_ex    = ctrl_q.alu_src;
    assign mem_to_reg_id_ex = ctrl_q.mem_to_reg;
    assign reg_write_id_ex  = ctrl_q.reg_write;
    assign mem_read_id_ex   = ctrl_q.mem_read;
    assign mem_write_id_ex  = ctrl_q.mem_write;
    assign branch_id_ex     = ctrl_q.branch;
    assign alu_op_id_ex     = ctrl_q.alu_op;
    assign func_id_ex       = func_q;
    assign illegal_id_ex    = illegal_q;
    assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_control_id_ex.sv
// Directed, table-driven bench for control_id_ex: decode table, stall/flush priority,
// illegal counting and saturation, and asynchronous reset.
module tb_control_id_ex;

    logic       clk;
    logic       rst;
    logic       valid_if_id, stall, flush;
    logic [5:0] opcode_if_id, func_if_id;

    logic       valid_id_ex, reg_dst_id_ex, alu_src_id_ex, mem_to_reg_id_ex, reg_write_id_ex;
    logic       mem_read_id_ex, mem_write_id_ex, branch_id_ex, illegal_id_ex;
    logic [1:0] alu_op_id_ex;
    logic [5:0] func_id_ex;
    logic [7:0] illegal_count;

    logic       s_valid_in, s_stall, s_flush;
    logic [5:0] s_op, s_fn;
    logic       s_valid, s_reg_dst, s_alu_src, s_mem_to_reg, s_reg_write;
    logic       s_mem_read, s_mem_write, s_branch, s_illegal;
    logic [1:0] s_alu_op;
    logic [5:0] s_func;
    logic [1:0] s_count;

    int checks   = 0;
    int failures = 0;

    control_id_ex #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid_if_id(valid_if_id), .opcode_if_id(opcode_if_id),
        .func_if_id(func_if_id), .stall(stall), .flush(flush), .valid_id_ex(valid_id_ex),
        .reg_dst_id_ex(reg_dst_id_ex), .alu_src_id_ex(alu_src_id_ex),
        .mem_to_reg_id_ex(mem_to_reg_id_ex), .reg_write_id_ex(reg_write_id_ex),
        .mem_read_id_ex(mem_read_id_ex), .mem_write_id_ex(mem_write_id_ex),
        .branch_id_ex(branch_id_ex), .alu_op_id_ex(alu_op_id_ex), .func_id_ex(func_id_ex),
        .illegal_id_ex(illegal_id_ex), .illegal_count(illegal_count)
    );

    control_id_ex #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .valid_if_id(s_valid_in), .opcode_if_id(s_op),
        .func_if_id(s_fn), .stall(s_stall), .flush(s_flush), .valid_id_ex(s_valid),
        .reg_dst_id_ex(s_reg_dst), .alu_src_id_ex(s_alu_src),
        .mem_to_reg_id_ex(s_mem_to_reg), .reg_write_id_ex(s_reg_write),
        .mem_read_id_ex(s_mem_read), .mem_write_id_ex(s_mem_write),
        .branch_id_ex(s_branch), .alu_op_id_ex(s_alu_op), .func_id_ex(s_func),
        .illegal_id_ex(s_illegal), .illegal_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits in order reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op.
    function automatic logic [8:0] ctrl_out();
        return {reg_dst_id_ex, alu_src_id_ex, mem_to_reg_id_ex, reg_write_id_ex,
                mem_read_id_ex, mem_write_id_ex, branch_id_ex, alu_op_id_ex};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [8:0] ec,
                             input logic [5:0] ef, input logic ei, input logic [7:0] ecnt);
        check({tag, ".valid"},   32'(valid_id_ex),   32'(ev));
        check({tag, ".ctrl"},    32'(ctrl_out()),    32'(ec));
        check({tag, ".func"},    32'(func_id_ex),    32'(ef));
        check({tag, ".illegal"}, 32'(illegal_id_ex), 32'(ei));
        check({tag, ".count"},   32'(illegal_count), 32'(ecnt));
    endtask

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic       st;
        logic       fl;
        logic       ev;
        logic [8:0] ec;
        logic [5:0] ef;
        logic       ei;
        logic [7:0] ecnt;
    } vec_t;

    localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;
    localparam logic [8:0] C_NONE = 9'b0;

    vec_t vecs[19];

    initial begin
        //            v   op      fn      st    fl    ev    ctrl    func    ill   cnt
        vecs[0]  = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, C_R,    6'h20, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 6'h23, 6'h15, 1'b0, 1'b0, 1'b1, C_LW,   6'h15, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 6'h2b, 6'h2a, 1'b0, 1'b0, 1'b1, C_SW,   6'h2a, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 6'h04, 6'h01, 1'b0, 1'b0, 1'b1, C_BEQ,  6'h01, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 6'h08, 6'h3f, 1'b0, 1'b0, 1'b1, C_ADDI, 6'h3f, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, C_NONE, 6'h00, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 6'h3f, 6'h0c, 1'b0, 1'b0, 1'b1, C_NONE, 6'h0c, 1'b1, 8'd1};
        vecs[7]  = '{1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b1, C_NONE, 6'h0c, 1'b1, 8'd1};
        vecs[8]  = '{1'b1, 6'h3f, 6'h00, 1'b1, 1'b0, 1'b1, C_NONE, 6'h0c, 1'b1, 8'd1};
        vecs[9]  = '{1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 1'b1, C_BEQ,  6'h00, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 6'h23, 6'h07, 1'b0, 1'b0, 1'b1, C_LW,   6'h07, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 6'h04, 6'h11, 1'b1, 1'b0, 1'b1, C_LW,   6'h07, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 6'h04, 6'h11, 1'b1, 1'b0, 1'b1, C_LW,   6'h07, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 6'h04, 6'h11, 1'b1, 1'b0, 1'b1, C_LW,   6'h07, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 6'h04, 6'h11, 1'b0, 1'b0, 1'b1, C_BEQ,  6'h11, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 6'h00, 6'h22, 1'b1, 1'b1, 1'b0, C_NONE, 6'h00, 1'b0, 8'd1};
        vecs[16] = '{1'b1, 6'h3f, 6'h05, 1'b0, 1'b1, 1'b0, C_NONE, 6'h00, 1'b0, 8'd1};
        vecs[17] = '{1'b0, 6'h3f, 6'h05, 1'b0, 1'b0, 1'b0, C_NONE, 6'h00, 1'b0, 8'd1};
        vecs[18] = '{1'b1, 6'h01, 6'h09, 1'b0, 1'b0, 1'b1, C_NONE, 6'h09, 1'b1, 8'd2};

        rst = 1'b1;
        valid_if_id = 1'b1; opcode_if_id = 6'h00; func_if_id = 6'h20; stall = 1'b0; flush = 1'b0;
        s_valid_in = 1'b0; s_op = 6'h3f; s_fn = 6'h00; s_stall = 1'b0; s_flush = 1'b0;

        #12;
        check_all("reset", 1'b0, C_NONE, 6'h00, 1'b0, 8'd0);
        check("reset.sat_count", 32'(s_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            valid_if_id  = vecs[i].v;
            opcode_if_id = vecs[i].op;
            func_if_id   = vecs[i].fn;
            stall        = vecs[i].st;
            flush        = vecs[i].fl;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ef,
                      vecs[i].ei, vecs[i].ecnt);
        end

        // Asynchronous reset mid-cycle, during a stall, after SW has been loaded.
        valid_if_id = 1'b1; opcode_if_id = 6'h2b; func_if_id = 6'h2b; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check_all("pre_rst_sw", 1'b1, C_SW, 6'h2b, 1'b0, 8'd2);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, C_NONE, 6'h00, 1'b0, 8'd0);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        opcode_if_id = 6'h08; func_if_id = 6'h13;
        @(posedge clk);
        #1;
        check_all("post_rst_addi", 1'b1, C_ADDI, 6'h13, 1'b0, 8'd0);

        // Saturation on the 2-bit counter instance: six illegal loads.
        s_valid_in = 1'b1; s_op = 6'h3f;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_count%0d", k), 32'(s_count), (k < 3) ? 32'(k) : 32'd3);
            check($sformatf("sat_illegal%0d", k), 32'(s_illegal), 32'd1);
        end
        s_valid_in = 1'b0;
        @(posedge clk);
        #1;
        check("sat_hold", 32'(s_count), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_id_ex.md
Name: control_id_ex

Overview:
- Main control decoder plus ID/EX control pipeline register. It produces the `alu_op_id_ex` / `func_id_ex` pair consumed by the ALU control decoder in EX, along with the remaining datapath control bits.
- Decodes the 6-bit opcode and funct of the IF/ID instruction and registers the result into the ID/EX stage.
- Supports hazard-unit stall (hold) and flush (bubble), and counts illegal opcodes.

Parameters:
- CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_if_id  input  1  IF/ID holds a real instruction.
- opcode_if_id  input  6  instr[31:26].
- func_if_id  input  6  instr[5:0].
- stall  input  1  hold ID/EX contents.
- flush  input  1  insert bubble into ID/EX.
- valid_id_ex  output  1  ID/EX holds a real instruction.
- reg_dst_id_ex  output  1  write rd (1) or rt (0).
- alu_src_id_ex  output  1  ALU B operand is immediate.
- mem_to_reg_id_ex  output  1  writeback from memory.
- reg_write_id_ex  output  1  register-file write enable.
- mem_read_id_ex  output  1  data-memory read.
- mem_write_id_ex  output  1  data-memory write.
- branch_id_ex  output  1  conditional branch.
- alu_op_id_ex  output  2  00 add, 01 subtract, 10 R-type funct, 11 unused.
- func_id_ex  output  6  funct forwarded to EX.
- illegal_id_ex  output  1  registered instruction had an unsupported opcode.
- illegal_count  output  CNT_W  saturating count of illegal opcodes accepted.

Behaviour:
- Reset: asynchronous and active-high. While rst=1, every output is 0, including illegal_count, and all control bits and alu_op=00.
- Decode table (combinational), bits listed as reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op:
  - R-type 000000: 1,0,0,1,0,0,0,10.
  - LW 100011: 0,1,1,1,1,0,0,00.
  - SW 101011: 0,1,0,0,0,1,0,00.
  - BEQ 000100: 0,0,0,0,0,0,1,01.
  - ADDI 001000: 0,1,0,1,0,0,0,00.
- Any other opcode: all control 0, alu_op=00, illegal=1.
- func is passed through for every opcode and is meaningful only when alu_op=10.
- Latency: 1 cycle. Values sampled at edge N are visible after edge N.
- Per-edge priority is flush > stall > load:
  - flush=1: bubble, i.e. valid=0, all control 0, alu_op=00, func=0, illegal=0. Applies even if stall=1 in the same cycle.
  - stall=1, flush=0: every ID/EX output holds its value.
  - Otherwise load: if valid_if_id=0, load a bubble; else load the decoded values, valid=1, illegal as decoded.
- An illegal opcode yields valid=1 with no side-effect bits set, so no write and no memory access. Trap handling is downstream.
- illegal_count:
  - Increments by 1 only on a load edge with valid_if_id=1 and an illegal opcode.
  - Saturates at 2^CNT_W-1; no wrap.
  - Unaffected by stall and flush.
  - Cleared only by rst.
- A held illegal instruction (stall) is counted once only.
- Reset asserted mid-stall or mid-stream clears immediately, without waiting for clk. The first edge after deassertion behaves as a normal load.

Decomposition:
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_FUNCT=2'b10;
  - a packed control-bundle typedef (7 flag bits + alu_op).
- The EX-side ALU control decoder imports the same ALU_OP constants.
- One sub-module, `main_decoder`: purely combinational opcode -> bundle + illegal flag. The top level holds the pipeline register, stall/flush priority and the counter.

Test Plan:
- Reset then load R-type ADD (op 000000, func 100000), valid=1 -> next cycle: reg_dst=1, reg_write=1, alu_op=10, func=100000, valid=1, illegal=0.
- LW, SW, BEQ, ADDI on consecutive cycles -> each appears one cycle later. Check alu_op sequence 00,00,01,00, mem_read only on LW, mem_write only on SW, branch only on BEQ.
- Load LW, then stall=1 for 3 cycles while the input changes to BEQ -> outputs stay LW for 3 cycles; BEQ appears on the first edge after stall drops.
- stall=1 and flush=1 together with R-type on input -> bubble: valid=0, all control 0, alu_op=00, func=0.
- Opcode 111111 valid, then stall 2 cycles -> illegal_id_ex=1, all control 0, illegal_count=1, not 3. With CNT_W=2, six illegal loads -> count saturates at 3.
- Assert rst asynchronously mid-cycle after loading SW -> outputs and illegal_count become 0 before the next clk edge. The first edge after release loads normally.
